// File: rtl/key_debounce_if.sv
// Push-button bus between the raw key source and the debouncer.
// The master drives the raw key. The slave returns the debounced events and the press count.
interface key_debounce_if;
    logic       KEY_In;
    logic       KEY_OK;
    logic       KEY_Release;
    logic       KEY_Level;
    logic [7:0] KEY_Count;

    modport master (
        output KEY_In,
        input  KEY_OK,
        input  KEY_Release,
        input  KEY_Level,
        input  KEY_Count
    );

    modport slave (
        input  KEY_In,
        output KEY_OK,
        output KEY_Release,
        output KEY_Level,
        output KEY_Count
    );
endinterface

// File: rtl/key_debounce.sv
// Debounces an active-low push-button and generates press, release and auto-repeat pulses.
// It also keeps a wrapping count of accepted presses. Every output is registered.
module key_debounce #(
    parameter logic [29:0] DEBOUNCE_T = 30'd1_000_000,
    parameter logic [29:0] HOLD_T     = 30'd25_000_000,
    parameter logic [29:0] REPEAT_T   = 30'd5_000_000,
    parameter logic        REPEAT_EN  = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    key_debounce_if.slave  key_bus
);
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic [29:0] r_cnt, w_cnt_next;
    logic        r_rep, w_rep_next;
    logic        r_sync1, r_sync2;
    logic        w_key_s;
    logic        r_ok, w_ok_next;
    logic        r_rel, w_rel_next;
    logic        r_lvl, w_lvl_next;
    logic [7:0]  r_count, w_count_next;
    logic [29:0] w_hold_target;

    // The synchronizer idles high (released), so the FSM sees a release during and right after reset.
    assign w_key_s       = ~r_sync2;
    assign w_hold_target = r_rep ? (REPEAT_T - 30'd1) : (HOLD_T - 30'd1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rep   <= 1'b0;
            r_ok    <= 1'b0;
            r_rel   <= 1'b0;
            r_lvl   <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= key_bus.KEY_In;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rep   <= w_rep_next;
            r_ok    <= w_ok_next;
            r_rel   <= w_rel_next;
            r_lvl   <= w_lvl_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rep_next   = r_rep;
        w_ok_next    = 1'b0;
        w_rel_next   = 1'b0;
        w_lvl_next   = r_lvl;
        w_count_next = r_count;
        case (r_state)
            IDLE: begin
                if (w_key_s) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_key_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == DEBOUNCE_T - 30'd1) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                    w_rep_next   = 1'b0;
                    w_ok_next    = 1'b1;
                    w_lvl_next   = 1'b1;
                    w_count_next = r_count + 8'd1;
                end else begin
                    w_cnt_next = r_cnt + 30'd1;
                end
            end
            PRESSED: begin
                // r_rep switches the hold target from the first-repeat delay to the repeat period.
                if (!w_key_s) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end else if (REPEAT_EN) begin
                    if (r_cnt == w_hold_target) begin
                        w_ok_next  = 1'b1;
                        w_cnt_next = '0;
                        w_rep_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 30'd1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (w_key_s) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                    w_rep_next   = 1'b0;
                end else if (r_cnt == DEBOUNCE_T - 30'd1) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_rel_next   = 1'b1;
                    w_lvl_next   = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + 30'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign key_bus.KEY_OK      = r_ok;
    assign key_bus.KEY_Release = r_rel;
    assign key_bus.KEY_Level   = r_lvl;
    assign key_bus.KEY_Count   = r_count;
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CLK and RST.
REQ-002 Parameter DEBOUNCE_T, default 30'd1_000_000, SHALL set the number of stable cycles required before a press or release is accepted.
REQ-003 Parameter HOLD_T, default 30'd25_000_000, SHALL set the number of cycles held in PRESSED before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_T, default 30'd5_000_000, SHALL set the number of cycles between subsequent auto-repeat pulses.
REQ-005 Parameter REPEAT_EN, default 1'b1, SHALL enable auto-repeat when 1 and suppress it when 0.
REQ-006 CLK  input  1  system clock; all state changes on the rising edge.
REQ-007 RST  input  1  synchronous active-high reset.
REQ-008 KEY_In  input  1  raw push-button, active-low, asynchronous, may bounce.
REQ-009 KEY_OK  output  1  one-cycle pulse per accepted press and per auto-repeat; feeds the LED/clock driver KEY_OK input.
REQ-010 KEY_Release  output  1  one-cycle pulse per accepted release.
REQ-011 KEY_Level  output  1  debounced pressed level, 1 = pressed.
REQ-012 KEY_Count  output  8  count of accepted presses, excluding repeats.

Function
REQ-013 KEY_In SHALL pass through a 2-flop synchronizer; key_s = inverted second flop, so 1 = pressed.
REQ-014 The FSM SHALL have states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus one 30-bit counter cnt.
REQ-015 In IDLE, key_s=1 SHALL go to PRESS_WAIT with cnt<=0; otherwise the FSM SHALL stay in IDLE.
REQ-016 In PRESS_WAIT, key_s=0 SHALL return to IDLE with no output pulse.
REQ-017 In PRESS_WAIT with key_s=1 and cnt==DEBOUNCE_T-1, the FSM SHALL go to PRESSED and register KEY_OK=1, KEY_Level=1, KEY_Count+1 and cnt<=0; otherwise cnt SHALL increment.
REQ-018 Press latency SHALL be exactly DEBOUNCE_T+3 edges, counted from the first edge sampling KEY_In=0, to KEY_OK high.
REQ-019 In PRESSED, key_s=0 SHALL go to RELEASE_WAIT with cnt<=0.
REQ-020 In PRESSED with REPEAT_EN=1, KEY_OK SHALL pulse when cnt reaches HOLD_T-1, then every REPEAT_T cycles while held; repeat pulses SHALL NOT change KEY_Count.
REQ-021 With REPEAT_EN=0, PRESSED SHALL produce no KEY_OK pulses.
REQ-022 In RELEASE_WAIT, key_s=1 SHALL return to PRESSED with cnt<=0 (hold timing restarts) and no KEY_OK pulse.
REQ-023 In RELEASE_WAIT with key_s=0 and cnt==DEBOUNCE_T-1, the FSM SHALL go to IDLE and register KEY_Release=1 and KEY_Level=0.
REQ-024 KEY_OK and KEY_Release SHALL each be high for exactly one cycle per event and never simultaneously.
REQ-025 KEY_Count SHALL wrap from 255 to 0.
REQ-026 KEY_Level SHALL stay 1 from the press-accept edge through the release-accept edge, including RELEASE_WAIT.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 RST=1 at a rising edge SHALL force state=IDLE, cnt=0, synchronizer flops=1 (released), KEY_OK=0, KEY_Release=0, KEY_Level=0 and KEY_Count=0.
REQ-029 RST SHALL take priority over every other event in the same cycle.
REQ-030 If reset occurs mid-press and the key is still held after reset, the block SHALL re-debounce from IDLE and issue a fresh KEY_OK.

Verification
REQ-031 Test parameters SHALL be DEBOUNCE_T=4, HOLD_T=10, REPEAT_T=5.
- KEY_In held 0 from edge 1 -> KEY_OK high only after edge 7, KEY_Level=1, KEY_Count=1.
- KEY_In low for 3 cycles then high -> no KEY_OK, KEY_Level stays 0, KEY_Count=0.
- Press accepted, then held 25 more cycles, REPEAT_EN=1 -> KEY_OK pulses at PRESSED cycles 10, 15, 20, 25; KEY_Count stays 1.
- Pressed, KEY_In high 2 cycles then low again -> no KEY_Release, no KEY_OK, KEY_Level stays 1; a later 6-cycle high -> one KEY_Release, KEY_Level=0.
- 256 clean press/release cycles -> KEY_Count returns to 0.
- RST pulsed in PRESSED while key held -> outputs 0 on the next edge, then KEY_OK again DEBOUNCE_T+3 edges after RST deasserts, KEY_Count=1.
